// File: rtl/toggle_pkg.sv
// Shared constants for TFF-signalled event paths (transmitter and receiver).
// Latency: n/a (package only).
// Backpressure: n/a.
package toggle_pkg;

  // Level that both ends of a toggle line come out of reset at.
  localparam logic TOG_RST_LVL = 1'b0;

  // Default synchronizer depth for lines crossing in from another domain.
  localparam int TOG_SYNC_DEF = 2;

  // Legal non-zero synchronizer depths. Depth 0 is also legal
  // (same-clock source).
  localparam int TOG_SYNC_MIN = 2;
  localparam int TOG_SYNC_MAX = 4;

  function automatic bit sync_stages_ok(input int n);
    return (n == 0) || ((n >= TOG_SYNC_MIN) && (n <= TOG_SYNC_MAX));
  endfunction

endpackage

// File: rtl/toggle_sync.sv
// Input synchronizer for a toggle line: DEPTH-flop chain, pass-through at DEPTH=0.
// Latency: DEPTH cycles. Backpressure: none (free-running level path).
// Ports: clk, rst_n (async active-low), din (raw line), dout (synchronized line).
module toggle_sync
  import toggle_pkg::*;
#(
  parameter int DEPTH = TOG_SYNC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (DEPTH == 0) begin : g_bypass
    // Source is already synchronous to clk; clock and reset are not needed.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout           = din;
  end else begin : g_chain
    logic [DEPTH-1:0] stage;

    // Reset to the line's idle level so release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage <= {DEPTH{TOG_RST_LVL}};
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/toggle_rx.sv
// Toggle-line receiver: each level transition becomes a pulse and a queued event.
// Latency: SYNC_STAGES+1 edges from tog_in change to evt_pulse/pend_cnt update.
// Backpressure: events queue in a saturating counter drained by evt_valid/evt_ready;
//               an event arriving while full (and not accepted) is dropped and sets ovf.
// Ports: clk, rst_n, tog_in, evt_ready, ovf_clr in; evt_pulse, evt_valid,
//        pend_cnt[CNT_W], ovf, tog_level out.
module toggle_rx
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES = TOG_SYNC_DEF,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tog_in,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_pulse,
  output logic             evt_valid,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf,
  output logic             tog_level
);

  if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("toggle_rx: SYNC_STAGES must be 0 or 2..4");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

  logic             s;
  logic             prev;
  logic             det;
  logic             take;
  logic             full;
  logic             ovf_set;
  logic [CNT_W-1:0] cnt_nxt;

  toggle_sync #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tog_in),
    .dout  (s)
  );

  assign tog_level = s;
  assign det       = s ^ prev;
  assign evt_valid = (pend_cnt != '0);
  assign take      = evt_valid & evt_ready;
  assign full      = (pend_cnt == CNT_FULL);

  // A new event and an accept in the same cycle cancel out, so a full
  // counter that is being drained never reports an overflow.
  always_comb begin
    cnt_nxt = pend_cnt;
    ovf_set = 1'b0;
    if (det && !take) begin
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        cnt_nxt = pend_cnt + CNT_ONE;
      end
    end else if (!det && take) begin
      cnt_nxt = pend_cnt - CNT_ONE;
    end
  end

  // prev resets to the line idle level: a line already high at release
  // yields exactly one event (transmitter was also in reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= TOG_RST_LVL;
      evt_pulse <= 1'b0;
      pend_cnt  <= '0;
      ovf       <= 1'b0;
    end else begin
      prev      <= s;
      evt_pulse <= det;
      pend_cnt  <= cnt_nxt;
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_rx.sv
// Bench for toggle_rx: two instances (SYNC_STAGES=0 and 2) share stimulus and
// are compared every cycle against an input-history model, plus literal checks.
module tb_toggle_rx;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tog_in = 1'b0;
  logic evt_ready = 1'b0;
  logic ovf_clr = 1'b0;

  logic             pul0, val0, ovf0, lvl0;
  logic [CNT_W-1:0] cnt0;
  logic             pul2, val2, ovf2, lvl2;
  logic [CNT_W-1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  toggle_rx #(.SYNC_STAGES(0), .CNT_W(CNT_W)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tog_in(tog_in), .evt_ready(evt_ready),
    .ovf_clr(ovf_clr), .evt_pulse(pul0), .evt_valid(val0), .pend_cnt(cnt0),
    .ovf(ovf0), .tog_level(lvl0)
  );

  toggle_rx #(.SYNC_STAGES(2), .CNT_W(CNT_W)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tog_in(tog_in), .evt_ready(evt_ready),
    .ovf_clr(ovf_clr), .evt_pulse(pul2), .evt_valid(val2), .pend_cnt(cnt2),
    .ovf(ovf2), .tog_level(lvl2)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[i] = tog_in as seen at the edge i edges ago (hist[0] = latest edge).
  // A receiver of depth D sees at edge k the input from edge k-D, so an event
  // is a difference between hist[D] and hist[D+1].
  logic [4:0] hist;
  int  m_cnt[2];
  bit  m_ovf[2];
  bit  m_pul[2];

  function automatic void step(input bit det, input bit rdy, input bit clr,
                               inout int cnt, inout bit ov, output bit pul);
    bit take;
    bit set;
    take = (cnt != 0) && rdy;
    set  = 1'b0;
    pul  = det;
    if (det && !take) begin
      if (cnt < CNT_MAX) cnt = cnt + 1;
      else set = 1'b1;
    end else if (!det && take) begin
      cnt = cnt - 1;
    end
    if (set) ov = 1'b1;
    else if (clr) ov = 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [4:0] h;
    bit p;
    if (!rst_n) begin
      hist = '0;
      for (int j = 0; j < 2; j++) begin
        m_cnt[j] = 0; m_ovf[j] = 1'b0; m_pul[j] = 1'b0;
      end
    end else begin
      h = {hist[3:0], tog_in};
      step(h[0] ^ h[1], evt_ready, ovf_clr, m_cnt[0], m_ovf[0], p); m_pul[0] = p;
      step(h[2] ^ h[3], evt_ready, ovf_clr, m_cnt[1], m_ovf[1], p); m_pul[1] = p;
      hist = h;
    end
  end

  // Compare every cycle, 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    check("d0_pulse", pul0, m_pul[0]);
    check("d0_valid", val0, m_cnt[0] != 0);
    check("d0_cnt",   cnt0, m_cnt[0]);
    check("d0_ovf",   ovf0, m_ovf[0]);
    check("d0_level", lvl0, tog_in);
    check("d2_pulse", pul2, m_pul[1]);
    check("d2_valid", val2, m_cnt[1] != 0);
    check("d2_cnt",   cnt2, m_cnt[1]);
    check("d2_ovf",   ovf2, m_ovf[1]);
    check("d2_level", lvl2, hist[1]);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset state.
    #2;
    check("rst_cnt0", cnt0, 0);
    check("rst_val2", val2, 0);
    check("rst_lvl2", lvl2, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet line: nothing may appear for 20 cycles.
    repeat (20) @(negedge clk);
    check("quiet_cnt0", cnt0, 0);
    check("quiet_cnt2", cnt2, 0);

    // Single rise: depth 0 reacts after edge N, depth 2 after edge N+2.
    @(negedge clk) tog_in = 1'b1;
    @(posedge clk) #1;
    check("lat_n_pul0", pul0, 1);
    check("lat_n_pul2", pul2, 0);
    @(posedge clk) #1;
    check("lat_n1_pul0", pul0, 0);
    check("lat_n1_pul2", pul2, 0);
    @(posedge clk) #1;
    check("lat_n2_pul2", pul2, 1);
    check("lat_n2_cnt2", cnt2, 1);
    check("lat_n2_val2", val2, 1);
    @(posedge clk) #1;
    check("lat_n3_pul2", pul2, 0);
    @(negedge clk) evt_ready = 1'b1;
    @(negedge clk) evt_ready = 1'b0;
    check("drain1_cnt2", cnt2, 0);

    // Three back-to-back toggles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) tog_in = ~tog_in;
      @(posedge clk) #1;
      check("b2b_pul0", pul0, 1);
    end
    @(negedge clk);
    check("b2b_cnt0", cnt0, 3);
    repeat (3) @(negedge clk);
    evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    evt_ready = 1'b0;
    check("b2b_drain_cnt0", cnt0, 0);
    check("b2b_drain_val0", val0, 0);
    check("b2b_drain_cnt2", cnt2, 0);

    // Saturation and overflow.
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk) tog_in = ~tog_in;
      @(posedge clk) #1;
      if (i == 15) begin
        check("sat15_cnt0", cnt0, 15);
        check("sat15_ovf0", ovf0, 0);
      end
      if (i == 16) begin
        check("sat16_cnt0", cnt0, 15);
        check("sat16_ovf0", ovf0, 1);
      end
    end
    repeat (4) @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    check("clr_ovf0", ovf0, 0);
    check("clr_cnt0", cnt0, 15);
    check("clr_ovf2", ovf2, 0);

    // Full counter: toggle together with accept -> no change, no overflow.
    @(negedge clk) begin
      tog_in = ~tog_in;
      evt_ready = 1'b1;
    end
    @(negedge clk) evt_ready = 1'b0;
    check("full_take_cnt0", cnt0, 15);
    check("full_take_ovf0", ovf0, 0);
    repeat (4) @(negedge clk);

    // Full counter: toggle together with ovf_clr -> set wins.
    @(negedge clk) begin
      tog_in = ~tog_in;
      ovf_clr = 1'b1;
    end
    @(negedge clk) ovf_clr = 1'b0;
    check("set_wins_ovf0", ovf0, 1);
    check("set_wins_cnt0", cnt0, 15);
    repeat (4) @(negedge clk);

    // Drain, then queue five events.
    evt_ready = 1'b1;
    repeat (16) @(negedge clk);
    evt_ready = 1'b0;
    check("drain_all_cnt0", cnt0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) tog_in = ~tog_in;
    end
    repeat (4) @(negedge clk);
    check("five_cnt0", cnt0, 5);
    check("five_cnt2", cnt2, 5);

    // Asynchronous reset mid-cycle.
    @(posedge clk) #3 rst_n = 1'b0;
    #1;
    check("arst_cnt0", cnt0, 0);
    check("arst_val0", val0, 0);
    check("arst_ovf0", ovf0, 0);
    check("arst_cnt2", cnt2, 0);
    check("arst_lvl2", lvl2, 0);
    check("arst_ovf2", ovf2, 0);
    tog_in = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_cnt0", cnt0, 0);
    check("post_rst_cnt2", cnt2, 0);

    // Line already high at reset release -> exactly one event.
    @(negedge clk) begin
      rst_n = 1'b0;
      tog_in = 1'b1;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("hi_rel_cnt0", cnt0, 1);
    check("hi_rel_cnt2", cnt2, 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
